// File: rtl/prng_pkg.sv
// prng_pkg: shared types and constants for the PRNG read-collector slice
package prng_pkg;
  localparam int WORD_W = 32;
  localparam int MAX_N = 1000;
  typedef enum logic [2:0] {IDLE, WAIT_WR, READ, DRAIN, TERM, DONE} state_e;
endpackage

// File: rtl/prng_read_collector_if.sv
// prng_read_collector_if: 32-bit valid/ready output stream with last marker
interface prng_read_collector_if;
  import prng_pkg::*;
  logic [WORD_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/prng_pair_fifo.sv
// prng_pair_fifo: first-word-fall-through sync FIFO with a 1- or 2-word push and 1-word pop
module prng_pair_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic clk,
  input  logic Reset,
  input  logic push,
  input  logic push2,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic pop,
  output logic [W-1:0] q,
  output logic empty,
  output logic [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, nw;
  logic rd;
  assign nw = CW'(push) + CW'(push && push2);
  assign rd = pop && !empty;
  assign empty = cnt == '0;
  assign q = mem[rp];
  assign free = CW'(DEPTH) - cnt;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= d0;
    if (push && push2) mem[wp + AW'(1)] <= d1;
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(nw);
      rp <= rp + AW'(rd);
      cnt <= cnt + nw - CW'(rd);
    end
  end
  // the upstream credit rule must keep every push within the free space
  always_ff @(posedge clk) assert (Reset || free >= nw);
endmodule

// File: rtl/prng_read_collector.sv
// prng_read_collector: requests paired BRAM reads after PRNG write-back and streams them with a running XOR checksum
module prng_read_collector
  import prng_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic Reset,
  input  logic [CNT_W-1:0] n,
  input  logic prngDone,
  input  logic busy,
  input  logic [WORD_W-1:0] readA,
  input  logic [WORD_W-1:0] readB,
  output logic readRqst,
  output logic done,
  output logic [WORD_W-1:0] checksum,
  prng_read_collector_if.master m
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e st, st_nx;
  logic [CNT_W-1:0] n_q, issued, captured, sent, pairs, outst;
  logic [READ_LAT-1:0] lat;
  logic [CW-1:0] free;
  logic pd_q, seen_busy, issue, cap, two, empty, xfer;
  assign pairs = n_q - (n_q >> 1);
  assign outst = issued - captured;
  assign cap = lat[READ_LAT-1];
  // odd n: the final pair's port-A word repeats index h and is dropped
  assign two = !(n_q[0] && captured == pairs - CNT_W'(1));
  assign m.m_valid = !empty;
  assign m.m_last = m.m_valid && sent == n_q - CNT_W'(1);
  assign xfer = m.m_valid && m.m_ready;
  assign done = st == DONE;
  prng_pair_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk(clk),
    .Reset(Reset),
    .push(cap),
    .push2(two),
    .d0(two ? readA : readB),
    .d1(readB),
    .pop(xfer),
    .q(m.m_data),
    .empty(empty),
    .free(free)
  );
  always_comb begin
    st_nx = st;
    issue = 1'b0;
    case (st)
      IDLE: if (prngDone && !pd_q) st_nx = n == '0 ? TERM : WAIT_WR;
      WAIT_WR: if (seen_busy && !busy && prngDone) st_nx = READ;
      READ: begin
        issue = issued != pairs && CNT_W'(free) >= (outst << 1) + CNT_W'(2);
        st_nx = issued == pairs ? DRAIN : READ;
      end
      DRAIN: if (captured == pairs) st_nx = TERM;
      TERM: st_nx = DONE;
      default: st_nx = st;
    endcase
    readRqst = issue || st == TERM;
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      st <= IDLE;
      n_q <= '0;
      issued <= '0;
      captured <= '0;
      sent <= '0;
      lat <= '0;
      pd_q <= 1'b0;
      seen_busy <= 1'b0;
      checksum <= '0;
    end else begin
      st <= st_nx;
      pd_q <= prngDone;
      if (st == IDLE && prngDone && !pd_q) n_q <= n;
      seen_busy <= st == WAIT_WR && (seen_busy || busy);
      issued <= issued + CNT_W'(issue);
      captured <= captured + CNT_W'(cap);
      lat <= READ_LAT'({lat, issue});
      if (xfer) begin
        sent <= sent + CNT_W'(1);
        checksum <= checksum ^ m.m_data;
      end
    end
  end
endmodule

// File: tb/tb_prng_read_collector.sv
// tb_prng_read_collector: random-data bench with a behavioural PRNG/BRAM model and stream scoreboard
module tb_prng_read_collector;
  import prng_pkg::*;
  logic clk = 0, Reset = 1, prngDone = 0, busy = 0, readRqst, done;
  logic [31:0] n = 0, readA, readB, checksum;
  prng_read_collector_if s();
  prng_read_collector #(.READ_LAT(2), .FIFO_DEPTH(16), .CNT_W(32)) dut (
    .clk(clk),
    .Reset(Reset),
    .n(n),
    .prngDone(prngDone),
    .busy(busy),
    .readA(readA),
    .readB(readB),
    .readRqst(readRqst),
    .done(done),
    .checksum(checksum),
    .m(s.master)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [MAX_N];
  logic [31:0] expq [$];
  logic [31:0] ck, hold_d, e_w;
  int h_m = 0, pairs_m = 0, rq_cnt = 0, p1 = -1, p2 = -1;
  int beats = 0, tests = 0, fails = 0, stall_left = 0;
  bit mon_en = 0, rmode = 0, hold_v = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // PRNG/BRAM model: the first P requests read pair k, data appears two edges after sampling
  always @(posedge clk) begin
    if (Reset) begin
      rq_cnt <= 0;
      p1 <= -1;
      p2 <= -1;
    end else begin
      rq_cnt <= rq_cnt + int'(readRqst);
      p1 <= (readRqst && rq_cnt < pairs_m) ? rq_cnt : -1;
      p2 <= p1;
    end
  end
  assign readA = p2 >= 0 ? mem[p2] : 32'hDEAD_BEEF;
  assign readB = p2 >= 0 ? mem[p2 + h_m] : 32'hBAD0_0BAD;
  initial begin
    s.m_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      s.m_ready = stall_left > 0 ? 1'b0 : (rmode ? 1'($urandom_range(0, 1)) : 1'b1);
      if (stall_left > 0) stall_left--;
    end
  end
  always @(negedge clk) if (!Reset && mon_en) begin
    if (hold_v) begin
      check("hold_valid", s.m_valid, 1);
      check("hold_data", s.m_data, hold_d);
    end
    hold_v = s.m_valid && !s.m_ready;
    hold_d = s.m_data;
    if (s.m_valid && s.m_ready) begin
      check("beat_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e_w = expq.pop_front();
        check("data", s.m_data, e_w);
        check("last", s.m_last, expq.size() == 0);
        ck ^= e_w;
      end
      beats++;
    end
  end
  task automatic reset_dut();
    @(negedge clk);
    mon_en = 0;
    prngDone = 0;
    busy = 0;
    Reset = 1;
    repeat (2) @(negedge clk);
    Reset = 0;
    @(negedge clk);
  endtask
  task automatic run(input int nn, input bit rnd, input int stall_at, input int abort_at);
    bit stalled = 0;
    h_m = nn / 2;
    pairs_m = nn - h_m;
    expq.delete();
    for (int i = 0; i < nn; i++) mem[i] = $urandom;
    for (int k = 0; k < h_m; k++) begin
      expq.push_back(mem[k]);
      expq.push_back(mem[k + h_m]);
    end
    if (nn % 2 == 1) expq.push_back(mem[nn - 1]);
    ck = 0;
    beats = 0;
    hold_v = 0;
    rmode = rnd;
    mon_en = 1;
    @(negedge clk);
    n = nn;
    prngDone = 1;
    repeat (2) @(negedge clk);
    busy = 1;
    repeat (3) @(negedge clk);
    busy = 0;
    n = $urandom;
    for (int c = 0; c < nn * 8 + 400 && !(done && expq.size() == 0); c++) begin
      @(negedge clk);
      if (stall_at > 0 && !stalled && rq_cnt >= stall_at) begin
        stalled = 1;
        stall_left = 30;
      end
      if (stalled && stall_left == 1) begin
        check("stall_inflight", rq_cnt * 2 - beats <= 16, 1);
        check("stall_throttled", rq_cnt < pairs_m, 1);
      end
      if (abort_at > 0 && beats >= abort_at) break;
    end
    if (abort_at > 0) check("abort_reached", beats >= abort_at, 1);
    else begin
      @(negedge clk);
      check("done", done, 1);
      check("beats", beats, nn);
      check("checksum", checksum, ck);
      check("rqst_cycles", rq_cnt, pairs_m + 1);
      check("rqst_idle", readRqst, 0);
      check("drained", s.m_valid, 0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_rqst", readRqst, 0);
    check("reset_valid", s.m_valid, 0);
    check("reset_last", s.m_last, 0);
    check("reset_done", done, 0);
    check("reset_checksum", checksum, 0);
    Reset = 0;
    @(negedge clk);
    check("idle_no_rqst", readRqst, 0);
    run(4, 0, 0, 0);
    reset_dut();
    run(5, 0, 0, 0);
    reset_dut();
    run(40, 0, 4, 0);
    reset_dut();
    run(0, 0, 0, 0);
    reset_dut();
    run(20, 0, 0, 7);
    Reset = 1;
    @(posedge clk);
    #1;
    check("abort_rqst", readRqst, 0);
    check("abort_valid", s.m_valid, 0);
    check("abort_last", s.m_last, 0);
    check("abort_done", done, 0);
    check("abort_checksum", checksum, 0);
    reset_dut();
    run(20, 0, 0, 0);
    reset_dut();
    run(20, 1, 0, 0);
    reset_dut();
    run(1000, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
